// File: rtl/wb_stage_arb_pkg.sv
// ----------------------------------------------------------------------------
// Package : wb_pkg
// Purpose : Shared encodings for the writeback stage: result-source select
//           codes, load-extension opcodes and the link-address offset.
// Ports   : none (package)
// ----------------------------------------------------------------------------
package wb_pkg;

    // Result source select. Code 2'd3 is unused upstream and falls back to ALU.
    localparam logic [1:0] SRC_ALU  = 2'd0;
    localparam logic [1:0] SRC_MEM  = 2'd1;
    localparam logic [1:0] SRC_LINK = 2'd2;

    // Load extension opcodes. Codes 5..7 are treated as a full-word load.
    localparam logic [2:0] LD_LW  = 3'd0;
    localparam logic [2:0] LD_LH  = 3'd1;
    localparam logic [2:0] LD_LHU = 3'd2;
    localparam logic [2:0] LD_LB  = 3'd3;
    localparam logic [2:0] LD_LBU = 3'd4;

    // Return address written by jump-and-link: the instruction after the delay slot.
    localparam int LINK_OFFSET = 8;

endpackage

// File: rtl/wb_stage_arb_if.sv
// ----------------------------------------------------------------------------
// Interface : wb_stage_arb_if
// Purpose   : Bundles the main-pipeline result, the side-channel handshake and
//             the register-file write port of the writeback stage.
// Signals   : m_*  main in-order pipeline result and load/link controls
//             s_*  side-channel valid/ready handshake with address and data
//             rf_* registered register-file write port
// Modports  : slave  - the writeback stage itself
//             master - the surrounding pipeline (or a testbench)
// ----------------------------------------------------------------------------
interface wb_stage_arb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) ();

    logic              m_valid;
    logic              m_reg_write;
    logic [ADDR_W-1:0] m_waddr;
    logic [1:0]        m_src;
    logic [2:0]        m_ld_op;
    logic [DATA_W-1:0] m_pc;
    logic [DATA_W-1:0] m_alu_result;
    logic [DATA_W-1:0] m_mem_rdata;

    logic              s_valid;
    logic              s_ready;
    logic [ADDR_W-1:0] s_waddr;
    logic [DATA_W-1:0] s_wdata;

    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    modport slave (
        input  m_valid, m_reg_write, m_waddr, m_src, m_ld_op, m_pc,
               m_alu_result, m_mem_rdata, s_valid, s_waddr, s_wdata,
        output s_ready, rf_we, rf_waddr, rf_wdata
    );

    modport master (
        output m_valid, m_reg_write, m_waddr, m_src, m_ld_op, m_pc,
               m_alu_result, m_mem_rdata, s_valid, s_waddr, s_wdata,
        input  s_ready, rf_we, rf_waddr, rf_wdata
    );

endinterface

// File: rtl/wb_stage_arb_load_ext.sv
// ----------------------------------------------------------------------------
// Module  : wb_load_ext
// Purpose : Combinational little-endian load extraction. Picks the halfword or
//           byte addressed by the low address bits and sign/zero extends it.
// Ports   : i_ldOp   [2:0]       load opcode (LW/LH/LHU/LB/LBU, others = LW)
//           i_offset [1:0]       byte offset within the aligned word
//           i_rdata  [DATA_W-1:0] raw aligned memory word
//           o_word   [DATA_W-1:0] extended result
// ----------------------------------------------------------------------------
module wb_load_ext
    import wb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]        i_ldOp,
    input  logic [1:0]        i_offset,
    input  logic [DATA_W-1:0] i_rdata,
    output logic [DATA_W-1:0] o_word
);

    logic [15:0] w_half;
    logic [7:0]  w_byte;

    // Little-endian: offset 0 selects the least significant byte/halfword.
    assign w_half = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];
    assign w_byte = i_rdata[{i_offset, 3'b000} +: 8];

    always_comb begin
        o_word = i_rdata;
        case (i_ldOp)
            LD_LH:   o_word = {{(DATA_W-16){w_half[15]}}, w_half};
            LD_LHU:  o_word = {{(DATA_W-16){1'b0}}, w_half};
            LD_LB:   o_word = {{(DATA_W-8){w_byte[7]}}, w_byte};
            LD_LBU:  o_word = {{(DATA_W-8){1'b0}}, w_byte};
            default: o_word = i_rdata;
        endcase
    end

endmodule

// File: rtl/wb_stage_arb.sv
// ----------------------------------------------------------------------------
// Module  : wb_stage_arb
// Purpose : Registered writeback stage. Merges the main in-order pipeline
//           result with a side channel of multicycle (mult/div) results onto
//           the single register-file write port. Main always wins; side results
//           are queued in a small FIFO and drained, in acceptance order, into
//           write slots the main pipeline leaves unused.
// Ports   : clk           rising-edge clock
//           rst_n         asynchronous active-low reset
//           bus           wb_stage_arb_if.slave (m_*, s_*, rf_* signals)
//           pending_mask  one bit per register with a queued side write
//                         (present only when WB_PENDING_EN is defined)
// Config  : WB_PENDING_EN - adds pending_mask for hazard/stall logic.
// ----------------------------------------------------------------------------
module wb_stage_arb
    import wb_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int SQ_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    wb_stage_arb_if.slave bus
`ifdef WB_PENDING_EN
    ,
    output logic [2**ADDR_W-1:0] pending_mask
`endif
);

    localparam int PTR_W = $clog2(SQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] r_qAddr [SQ_DEPTH];
    logic [DATA_W-1:0] r_qData [SQ_DEPTH];
    logic [PTR_W-1:0]  r_rdPtr;
    logic [PTR_W-1:0]  r_wrPtr;
    logic [CNT_W-1:0]  r_count;

    logic              r_rfWe;
    logic [ADDR_W-1:0] r_rfWaddr;
    logic [DATA_W-1:0] r_rfWdata;

    logic              w_mainWr;
    logic              w_accept;
    logic              w_acceptNz;
    logic              w_notEmpty;
    logic              w_pop;
    logic              w_push;
    logic              w_bypass;
    logic [DATA_W-1:0] w_loadWord;
    logic [DATA_W-1:0] w_mainData;

    wb_load_ext #(.DATA_W(DATA_W)) u_loadExt (
        .i_ldOp   (bus.m_ld_op),
        .i_offset (bus.m_alu_result[1:0]),
        .i_rdata  (bus.m_mem_rdata),
        .o_word   (w_loadWord)
    );

    // Writes to $0 are architecturally void, so they never claim the slot.
    assign w_mainWr   = bus.m_valid & bus.m_reg_write & (bus.m_waddr != '0);
    assign w_notEmpty = (r_count != '0);

    // Ready depends only on occupancy so no combinational path exists from m_*.
    assign bus.s_ready = (r_count < CNT_W'(SQ_DEPTH));
    assign w_accept    = bus.s_valid & bus.s_ready;
    assign w_acceptNz  = w_accept & (bus.s_waddr != '0);

    // The FIFO head drains before a new side result can bypass it, which keeps
    // side results in acceptance order. A push when full cannot happen
    // because ready is low then.
    assign w_pop    = ~w_mainWr & w_notEmpty;
    assign w_bypass = ~w_mainWr & ~w_notEmpty & w_acceptNz;
    assign w_push   = w_acceptNz & ~w_bypass;

    // Main result selection; source code 3 falls back to the ALU result.
    always_comb begin
        w_mainData = bus.m_alu_result;
        case (bus.m_src)
            SRC_MEM:  w_mainData = w_loadWord;
            SRC_LINK: w_mainData = bus.m_pc + DATA_W'(LINK_OFFSET);
            default:  w_mainData = bus.m_alu_result;
        endcase
    end

    // FIFO pointers and occupancy; reset discards anything still queued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage needs no reset: only slots covered by count are ever read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_qAddr[r_wrPtr] <= bus.s_waddr;
            r_qData[r_wrPtr] <= bus.s_wdata;
        end
    end

    // Register-file write port; address and data hold when no slot is used.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rfWe    <= 1'b0;
            r_rfWaddr <= '0;
            r_rfWdata <= '0;
        end else begin
            r_rfWe <= w_mainWr | w_pop | w_bypass;
            if (w_mainWr) begin
                r_rfWaddr <= bus.m_waddr;
                r_rfWdata <= w_mainData;
            end else if (w_pop) begin
                r_rfWaddr <= r_qAddr[r_rdPtr];
                r_rfWdata <= r_qData[r_rdPtr];
            end else if (w_bypass) begin
                r_rfWaddr <= bus.s_waddr;
                r_rfWdata <= bus.s_wdata;
            end
        end
    end

    assign bus.rf_we    = r_rfWe;
    assign bus.rf_waddr = r_rfWaddr;
    assign bus.rf_wdata = r_rfWdata;

`ifdef WB_PENDING_EN
    // A slot is live when its distance from the read pointer is below count,
    // so the mask follows push/pop at the same edge that moves the pointers.
    always_comb begin
        pending_mask = '0;
        for (int j = 0; j < SQ_DEPTH; j++) begin
            if ({1'b0, PTR_W'(PTR_W'(j) - r_rdPtr)} < r_count)
                pending_mask[r_qAddr[j]] = 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_wb_stage_arb.sv
// ----------------------------------------------------------------------------
// Testbench : tb_wb_stage_arb
// Purpose   : Directed, table-driven checks of the writeback stage: load
//             extraction, link address, $0 suppression, bypass, main/side
//             collision ordering, mid-stream reset and (with WB_PENDING_EN)
//             the pending mask.
// ----------------------------------------------------------------------------
module tb_wb_stage_arb;

    localparam int DW = 32;
    localparam int AW = 5;

    typedef struct {
        logic        mValid;
        logic        mRegWrite;
        logic [4:0]  mWaddr;
        logic [1:0]  mSrc;
        logic [2:0]  mLdOp;
        logic [31:0] mPc;
        logic [31:0] mAlu;
        logic        sValid;
        logic [4:0]  sWaddr;
        logic [31:0] sWdata;
        logic        expWe;
        logic [4:0]  expWaddr;
        logic [31:0] expWdata;
    } vec_t;

    localparam logic [31:0] MEM_WORD = 32'h8081F2F3;
    localparam int NVEC = 17;

    logic clk;
    logic rst_n;
    int   assertCount;
    int   failCount;
    vec_t vecs [NVEC];

    wb_stage_arb_if #(.DATA_W(DW), .ADDR_W(AW)) busIf ();

`ifdef WB_PENDING_EN
    logic [2**AW-1:0] pendingMask;
`endif

    wb_stage_arb #(.DATA_W(DW), .ADDR_W(AW), .SQ_DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busIf)
`ifdef WB_PENDING_EN
        ,
        .pending_mask (pendingMask)
`endif
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case anything stalls the sequence.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mkVec(
        input logic mv, input logic rw, input logic [4:0] wa, input logic [1:0] src,
        input logic [2:0] ld, input logic [31:0] pc, input logic [31:0] alu,
        input logic sv, input logic [4:0] swa, input logic [31:0] swd,
        input logic ewe, input logic [4:0] ewa, input logic [31:0] ewd);
        vec_t v;
        v.mValid = mv;  v.mRegWrite = rw; v.mWaddr = wa; v.mSrc = src;
        v.mLdOp = ld;   v.mPc = pc;       v.mAlu = alu;
        v.sValid = sv;  v.sWaddr = swa;   v.sWdata = swd;
        v.expWe = ewe;  v.expWaddr = ewa; v.expWdata = ewd;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h required %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        busIf.m_valid      = v.mValid;
        busIf.m_reg_write  = v.mRegWrite;
        busIf.m_waddr      = v.mWaddr;
        busIf.m_src        = v.mSrc;
        busIf.m_ld_op      = v.mLdOp;
        busIf.m_pc         = v.mPc;
        busIf.m_alu_result = v.mAlu;
        busIf.m_mem_rdata  = MEM_WORD;
        busIf.s_valid      = v.sValid;
        busIf.s_waddr      = v.sWaddr;
        busIf.s_wdata      = v.sWdata;
    endtask

    // One clock: drive after the falling edge, check ready before the rising
    // edge, check the registered write port just after it.
    task automatic stepCycle(input string tag, input vec_t v, input logic expReady);
        @(negedge clk);
        applyStimulus(v);
        #1;
        checkOutput({tag, ".s_ready"}, 32'(busIf.s_ready), 32'(expReady));
        @(posedge clk);
        #1;
        checkOutput({tag, ".rf_we"},    32'(busIf.rf_we),    32'(v.expWe));
        checkOutput({tag, ".rf_waddr"}, 32'(busIf.rf_waddr), 32'(v.expWaddr));
        checkOutput({tag, ".rf_wdata"}, busIf.rf_wdata,      v.expWdata);
    endtask

    function automatic vec_t mainAlu(input logic [4:0] wa, input logic [31:0] d,
                                     input logic sv, input logic [4:0] swa, input logic [31:0] swd,
                                     input logic ewe, input logic [4:0] ewa, input logic [31:0] ewd);
        return mkVec(1'b1, 1'b1, wa, 2'd0, 3'd0, 32'h0, d, sv, swa, swd, ewe, ewa, ewd);
    endfunction

    function automatic vec_t idle(input logic sv, input logic [4:0] swa, input logic [31:0] swd,
                                  input logic ewe, input logic [4:0] ewa, input logic [31:0] ewd);
        return mkVec(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0, sv, swa, swd, ewe, ewa, ewd);
    endfunction

    initial begin
        assertCount = 0;
        failCount   = 0;

        //        mv  rw  wa  src ld  pc            alu           sv  swa  swd         we  ewa  ewd
        vecs[0]  = mkVec(1, 1, 1,  1, 3, 32'h100,      32'h1000,     0, 0, 32'h0,      1, 1,  32'hFFFFFFF3);
        vecs[1]  = mkVec(1, 1, 2,  1, 4, 32'h100,      32'h1002,     0, 0, 32'h0,      1, 2,  32'h00000081);
        vecs[2]  = mkVec(1, 1, 3,  1, 1, 32'h100,      32'h1002,     0, 0, 32'h0,      1, 3,  32'hFFFF8081);
        vecs[3]  = mkVec(1, 1, 4,  1, 2, 32'h100,      32'h1000,     0, 0, 32'h0,      1, 4,  32'h0000F2F3);
        vecs[4]  = mkVec(1, 1, 5,  1, 0, 32'h100,      32'h1003,     0, 0, 32'h0,      1, 5,  32'h8081F2F3);
        vecs[5]  = mkVec(1, 1, 6,  1, 7, 32'h100,      32'h1001,     0, 0, 32'h0,      1, 6,  32'h8081F2F3);
        vecs[6]  = mkVec(1, 1, 7,  1, 3, 32'h100,      32'h1003,     0, 0, 32'h0,      1, 7,  32'hFFFFFF80);
        vecs[7]  = mkVec(1, 1, 8,  1, 4, 32'h100,      32'h1001,     0, 0, 32'h0,      1, 8,  32'h000000F2);
        vecs[8]  = mkVec(1, 1, 9,  0, 0, 32'h100,      32'hDEADBEEF, 0, 0, 32'h0,      1, 9,  32'hDEADBEEF);
        vecs[9]  = mkVec(1, 1, 10, 3, 3, 32'h100,      32'h12345678, 0, 0, 32'h0,      1, 10, 32'h12345678);
        vecs[10] = mkVec(1, 1, 31, 2, 0, 32'h00003000, 32'h0,        0, 0, 32'h0,      1, 31, 32'h00003008);
        vecs[11] = mkVec(1, 1, 2,  2, 0, 32'hFFFFFFFC, 32'h0,        0, 0, 32'h0,      1, 2,  32'h00000004);
        vecs[12] = mkVec(1, 1, 0,  0, 0, 32'h100,      32'h55,       0, 0, 32'h0,      0, 2,  32'h00000004);
        vecs[13] = mkVec(0, 1, 9,  0, 0, 32'h100,      32'h66,       0, 0, 32'h0,      0, 2,  32'h00000004);
        vecs[14] = mkVec(1, 0, 9,  0, 0, 32'h100,      32'h77,       0, 0, 32'h0,      0, 2,  32'h00000004);
        vecs[15] = mkVec(0, 0, 0,  0, 0, 32'h100,      32'h0,        1, 5, 32'h1234,   1, 5,  32'h00001234);
        vecs[16] = mkVec(0, 0, 0,  0, 0, 32'h100,      32'h0,        1, 0, 32'hABCD,   0, 5,  32'h00001234);

        // Reset state.
        rst_n = 1'b0;
        applyStimulus(idle(0, 0, 0, 0, 0, 0));
        #2;
        checkOutput("reset.rf_we",    32'(busIf.rf_we),    32'h0);
        checkOutput("reset.rf_waddr", 32'(busIf.rf_waddr), 32'h0);
        checkOutput("reset.rf_wdata", busIf.rf_wdata,      32'h0);
        checkOutput("reset.s_ready",  32'(busIf.s_ready),  32'h1);
        @(negedge clk);
        rst_n = 1'b1;

        // Single-cycle vectors: loads, ALU, link, $0 suppression, bypass.
        for (int i = 0; i < NVEC; i++)
            stepCycle($sformatf("vec%0d", i), vecs[i], 1'b1);

        // Collision: main busy for 3 cycles while the side offers 3 results.
        // The bypass and $0 side entries above must have left the FIFO empty.
        stepCycle("col1", mainAlu(10, 32'hA0, 1, 20, 32'h200, 1, 10, 32'hA0), 1'b1);
        stepCycle("col2", mainAlu(11, 32'hA1, 1, 21, 32'h210, 1, 11, 32'hA1), 1'b1);
        stepCycle("col3", mainAlu(12, 32'hA2, 1, 22, 32'h220, 1, 12, 32'hA2), 1'b0);
        stepCycle("col4", idle(1, 22, 32'h220, 1, 20, 32'h200), 1'b0);
        stepCycle("col5", idle(1, 22, 32'h220, 1, 21, 32'h210), 1'b1);
        stepCycle("col6", idle(0, 0, 32'h0,    1, 22, 32'h220), 1'b1);
        stepCycle("col7", idle(0, 0, 32'h0,    0, 22, 32'h220), 1'b1);

        // Mid-stream reset with two entries queued.
        stepCycle("rst1", mainAlu(1, 32'h11, 1, 3, 32'h33, 1, 1, 32'h11), 1'b1);
        stepCycle("rst2", mainAlu(2, 32'h22, 1, 4, 32'h44, 1, 2, 32'h22), 1'b1);
        @(negedge clk);
        applyStimulus(mainAlu(5, 32'h55, 0, 0, 32'h0, 0, 0, 32'h0));
        rst_n = 1'b0;
        #1;
        checkOutput("midrst.rf_we",    32'(busIf.rf_we),    32'h0);
        checkOutput("midrst.rf_waddr", 32'(busIf.rf_waddr), 32'h0);
        checkOutput("midrst.rf_wdata", busIf.rf_wdata,      32'h0);
        checkOutput("midrst.s_ready",  32'(busIf.s_ready),  32'h1);
        @(negedge clk);
        applyStimulus(idle(0, 0, 0, 0, 0, 0));
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++)
            stepCycle($sformatf("post%0d", i), idle(0, 0, 32'h0, 0, 0, 32'h0), 1'b1);

`ifdef WB_PENDING_EN
        // r7 stays pending while main holds the slot, clears when popped.
        stepCycle("pend1", mainAlu(1, 32'h1, 1, 7, 32'h77, 1, 1, 32'h1), 1'b1);
        checkOutput("pend1.mask", pendingMask, 32'h00000080);
        stepCycle("pend2", mainAlu(2, 32'h2, 0, 0, 32'h0, 1, 2, 32'h2), 1'b1);
        checkOutput("pend2.mask", pendingMask, 32'h00000080);
        stepCycle("pend3", idle(0, 0, 32'h0, 1, 7, 32'h77), 1'b1);
        checkOutput("pend3.mask", pendingMask, 32'h00000000);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
